// File: rtl/gshare_branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : gshare_branch_predictor_if
// Description : Fetch-side lookup bus and EX-side training bus for the
//               gshare/bimodal next-PC predictor.
// Revision    : 1.0  initial release
// ============================================================================
interface gshare_branch_predictor_if #(
  parameter int BHR_WIDTH = 5
);
  // Fetch lookup
  logic [31:0]          pc;
  logic [31:0]          next_pc;
  logic                 pred_taken;
  logic [BHR_WIDTH-1:0] pred_index;

  // EX resolution / training
  logic                 update_valid;
  logic                 update_is_jump;
  logic [31:0]          update_pc;
  logic [BHR_WIDTH-1:0] update_index;
  logic                 update_taken;
  logic [31:0]          update_target;

  // Pipeline side: drives fetch PC and resolved outcomes
  modport master (
    output pc, update_valid, update_is_jump, update_pc,
           update_index, update_taken, update_target,
    input  next_pc, pred_taken, pred_index
  );

  // Predictor side
  modport slave (
    input  pc, update_valid, update_is_jump, update_pc,
           update_index, update_taken, update_target,
    output next_pc, pred_taken, pred_index
  );
endinterface
`default_nettype wire

// File: rtl/gshare_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : gshare_branch_predictor
// Description : IF-stage next-PC predictor. Direct-mapped BTB plus a table of
//               2-bit saturating counters. Lookup is combinational; training
//               from EX is registered and visible one cycle later.
//               Optional macro GSHARE_PRED_EN: counter index is
//               pc ^ global history (gshare). Without it the predictor is
//               bimodal (index = pc bits, no history register).
// Revision    : 1.0  initial release
// ============================================================================
module gshare_branch_predictor #(
  parameter int BHR_WIDTH    = 5,
  parameter int BTB_IDX_BITS = 5
) (
  input  wire logic                      clk,
  input  wire logic                      reset,
  gshare_branch_predictor_if.slave       bus_if
);

  localparam int PHT_DEPTH = 1 << BHR_WIDTH;
  localparam int BTB_DEPTH = 1 << BTB_IDX_BITS;
  localparam int TAG_W     = 30 - BTB_IDX_BITS;

  localparam logic [1:0] CNT_STRONG_NT = 2'b00;
  localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
  localparam logic [1:0] CNT_STRONG_T  = 2'b11;

  // Storage
  logic [1:0]          pht_q        [PHT_DEPTH];
  logic [BTB_DEPTH-1:0] btb_valid_q;
  logic [BTB_DEPTH-1:0] btb_jump_q;
  logic [TAG_W-1:0]    btb_tag_q    [BTB_DEPTH];
  logic [31:0]         btb_target_q [BTB_DEPTH];

  // History seen by the lookup (zero in the bimodal build)
  logic [BHR_WIDTH-1:0] w_hist;

  // Lookup-side decode
  logic [BTB_IDX_BITS-1:0] w_lk_btb_idx;
  logic [TAG_W-1:0]        w_lk_tag;
  logic [BHR_WIDTH-1:0]    w_lk_pht_idx;
  logic                    w_lk_hit;

  // Update-side decode
  logic [BTB_IDX_BITS-1:0] w_up_btb_idx;
  logic [TAG_W-1:0]        w_up_tag;
  logic [1:0]              cnt_cur;
  logic [1:0]              cnt_d;

  // Byte-offset bits of word-aligned PCs carry no information
  logic w_unused_bits;
  assign w_unused_bits = ^{bus_if.pc[1:0], bus_if.update_pc[1:0]};

`ifdef GSHARE_PRED_EN
  logic [BHR_WIDTH-1:0] bhr_q;
  logic [BHR_WIDTH-1:0] bhr_d;

  assign bhr_d  = {bhr_q[BHR_WIDTH-2:0], bus_if.update_taken};
  assign w_hist = bhr_q;

  // Non-speculative history: only resolved conditional branches shift in
  always_ff @(posedge clk) begin
    if (reset) begin
      bhr_q <= '0;
    end else if (bus_if.update_valid && !bus_if.update_is_jump) begin
      bhr_q <= bhr_d;
    end
  end
`else
  assign w_hist = '0;
`endif

  assign w_lk_btb_idx = bus_if.pc[BTB_IDX_BITS+1:2];
  assign w_lk_tag     = bus_if.pc[31:BTB_IDX_BITS+2];
  assign w_lk_pht_idx = bus_if.pc[BHR_WIDTH+1:2] ^ w_hist;
  assign w_lk_hit     = btb_valid_q[w_lk_btb_idx] &&
                        (btb_tag_q[w_lk_btb_idx] == w_lk_tag);

  // Zero-latency prediction from the current storage contents (no update bypass)
  always_comb begin
    bus_if.pred_index = w_lk_pht_idx;
    bus_if.pred_taken = w_lk_hit &&
                        (btb_jump_q[w_lk_btb_idx] || pht_q[w_lk_pht_idx][1]);
    bus_if.next_pc    = bus_if.pred_taken ? btb_target_q[w_lk_btb_idx]
                                          : (bus_if.pc + 32'd4);
  end

  assign w_up_btb_idx = bus_if.update_pc[BTB_IDX_BITS+1:2];
  assign w_up_tag     = bus_if.update_pc[31:BTB_IDX_BITS+2];
  assign cnt_cur      = pht_q[bus_if.update_index];

  // Saturating step of the counter being trained
  always_comb begin
    cnt_d = cnt_cur;
    if (bus_if.update_taken) begin
      if (cnt_cur != CNT_STRONG_T) cnt_d = cnt_cur + 2'd1;
    end else begin
      if (cnt_cur != CNT_STRONG_NT) cnt_d = cnt_cur - 2'd1;
    end
  end

  // Counter table: reset to weak-NT, trained only by conditional branches
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PHT_DEPTH; i++) begin
        pht_q[i] <= CNT_WEAK_NT;
      end
    end else if (bus_if.update_valid && !bus_if.update_is_jump) begin
      pht_q[bus_if.update_index] <= cnt_d;
    end
  end

  // BTB valid/kind bits: any taken resolution claims its direct-mapped slot
  always_ff @(posedge clk) begin
    if (reset) begin
      btb_valid_q <= '0;
      btb_jump_q  <= '0;
    end else if (bus_if.update_valid && bus_if.update_taken) begin
      btb_valid_q[w_up_btb_idx] <= 1'b1;
      btb_jump_q[w_up_btb_idx]  <= bus_if.update_is_jump;
    end
  end

  // BTB payload: no reset needed, qualified by the valid bits
  always_ff @(posedge clk) begin
    if (!reset && bus_if.update_valid && bus_if.update_taken) begin
      btb_tag_q[w_up_btb_idx]    <= w_up_tag;
      btb_target_q[w_up_btb_idx] <= bus_if.update_target;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gshare_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_gshare_branch_predictor
// Description : Directed self-checking bench for gshare_branch_predictor with
//               a behavioural reference model and an expected-result queue.
//               Follows GSHARE_PRED_EN the same way the design does.
// Revision    : 1.0  initial release
// ============================================================================
module tb_gshare_branch_predictor;

  localparam int BHR_WIDTH    = 5;
  localparam int BTB_IDX_BITS = 5;

  typedef struct packed {
    logic [31:0]          next_pc;
    logic                 taken;
    logic [BHR_WIDTH-1:0] idx;
  } exp_t;

  logic clk;
  logic reset;

  gshare_branch_predictor_if #(.BHR_WIDTH(BHR_WIDTH)) bus_if ();

  gshare_branch_predictor #(
    .BHR_WIDTH    (BHR_WIDTH),
    .BTB_IDX_BITS (BTB_IDX_BITS)
  ) u_dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [1:0]  m_pht    [32];
  logic        m_valid  [32];
  logic        m_jump   [32];
  logic [24:0] m_tag    [32];
  logic [31:0] m_target [32];
  logic [4:0]  m_bhr;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_pht[i]   = 2'b01;
      m_valid[i] = 1'b0;
      m_jump[i]  = 1'b0;
      m_tag[i]   = '0;
      m_target[i] = '0;
    end
    m_bhr = '0;
  endtask

  function automatic exp_t model_predict(input logic [31:0] pc);
    exp_t e;
    int   b;
    logic hit;
    b = int'(pc[6:2]);
    hit = m_valid[b] && (m_tag[b] == pc[31:7]);
    e.idx   = pc[6:2] ^ m_bhr;
    e.taken = hit && (m_jump[b] || m_pht[e.idx][1]);
    e.next_pc = e.taken ? m_target[b] : pc + 32'd4;
    return e;
  endfunction

  task automatic model_update(input logic is_jump, input logic [31:0] pc,
                              input logic [4:0] idx, input logic taken,
                              input logic [31:0] target);
    int b;
    b = int'(pc[6:2]);
    if (!is_jump) begin
      if (taken && m_pht[idx] != 2'b11) m_pht[idx] = m_pht[idx] + 2'd1;
      if (!taken && m_pht[idx] != 2'b00) m_pht[idx] = m_pht[idx] - 2'd1;
`ifdef GSHARE_PRED_EN
      m_bhr = {m_bhr[3:0], taken};
`endif
    end
    if (taken) begin
      m_valid[b]  = 1'b1;
      m_jump[b]   = is_jump;
      m_tag[b]    = pc[31:7];
      m_target[b] = target;
    end
  endtask

  // Pop the oldest expectation and compare against the live outputs
  task automatic check_outputs(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_total++;
      $error("FAIL %s: scoreboard empty, observed none required one entry", tag);
      return;
    end
    e = sb.pop_front();
    n_total++;
    assert (bus_if.next_pc === e.next_pc) n_pass++;
    else $error("FAIL %s.next_pc: observed %h required %h", tag, bus_if.next_pc, e.next_pc);
    n_total++;
    assert (bus_if.pred_taken === e.taken) n_pass++;
    else $error("FAIL %s.pred_taken: observed %b required %b", tag, bus_if.pred_taken, e.taken);
    n_total++;
    assert (bus_if.pred_index === e.idx) n_pass++;
    else $error("FAIL %s.pred_index: observed %h required %h", tag, bus_if.pred_index, e.idx);
  endtask

  // Present a fetch PC mid-cycle and check the same-cycle prediction
  task automatic lookup(input logic [31:0] pc, input string tag,
                        output logic [4:0] idx);
    exp_t e;
    @(negedge clk);
    bus_if.pc = pc;
    e = model_predict(pc);
    idx = e.idx;
    sb.push_back(e);
    #2;
    check_outputs(tag);
  endtask

  // One EX resolution; optionally with reset asserted in the same cycle
  task automatic update(input logic is_jump, input logic [31:0] pc,
                        input logic [4:0] idx, input logic taken,
                        input logic [31:0] target, input logic with_reset);
    @(negedge clk);
    bus_if.update_valid   = 1'b1;
    bus_if.update_is_jump = is_jump;
    bus_if.update_pc      = pc;
    bus_if.update_index   = idx;
    bus_if.update_taken   = taken;
    bus_if.update_target  = target;
    reset                 = with_reset;
    @(posedge clk);
    #1;
    bus_if.update_valid = 1'b0;
    reset               = 1'b0;
    if (with_reset) model_reset();
    else            model_update(is_jump, pc, idx, taken, target);
  endtask

  logic [4:0] idx;
  logic [4:0] idx_unused;
  exp_t       e_same;

  initial begin
    reset                 = 1'b1;
    bus_if.pc             = 32'h100;
    bus_if.update_valid   = 1'b0;
    bus_if.update_is_jump = 1'b0;
    bus_if.update_pc      = '0;
    bus_if.update_index   = '0;
    bus_if.update_taken   = 1'b0;
    bus_if.update_target  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    lookup(32'h100, "reset_pc100", idx);

    // Conditional taken branch, then refetch
    update(1'b0, 32'h100, idx, 1'b1, 32'h80, 1'b0);
    lookup(32'h100, "refetch_pc100", idx_unused);

    // Counter saturation at index 0
    for (int i = 0; i < 5; i++) update(1'b0, 32'h100, 5'd0, 1'b1, 32'h80, 1'b0);
    lookup(32'h100, "sat_top", idx_unused);
    update(1'b0, 32'h100, 5'd0, 1'b0, 32'h80, 1'b0);
    lookup(32'h100, "strong_to_weak_t", idx_unused);
    update(1'b0, 32'h100, 5'd0, 1'b0, 32'h80, 1'b0);
    lookup(32'h100, "weak_t_to_weak_nt", idx_unused);
    for (int i = 0; i < 3; i++) update(1'b0, 32'h100, 5'd0, 1'b0, 32'h80, 1'b0);
    lookup(32'h100, "floor_no_wrap", idx_unused);
    for (int i = 0; i < 2; i++) update(1'b0, 32'h100, 5'd0, 1'b0, 32'h80, 1'b0);
    lookup(32'h100, "floor_hist_clear", idx_unused);
    update(1'b0, 32'h100, 5'd0, 1'b1, 32'h80, 1'b0);
    lookup(32'h100, "floor_plus_one", idx_unused);

    // Unconditional jump ignores counters, leaves history alone
    lookup(32'h200, "jal_before", idx);
    update(1'b1, 32'h200, idx, 1'b1, 32'h400, 1'b0);
    lookup(32'h200, "jal_after", idx_unused);
    lookup(32'h0, "hist_after_jal", idx_unused);

    // Aliasing in the direct-mapped BTB
    lookup(32'h100, "alias_a_fetch", idx);
    update(1'b0, 32'h100, idx, 1'b1, 32'h80, 1'b0);
    lookup(32'h180, "alias_b_fetch", idx);
    update(1'b0, 32'h180, idx, 1'b1, 32'h300, 1'b0);
    lookup(32'h100, "alias_evicted", idx_unused);
    lookup(32'h180, "alias_owner", idx_unused);

    // Same-cycle lookup and install of the same entry sees the old contents
    @(negedge clk);
    bus_if.pc             = 32'h300;
    e_same                = model_predict(32'h300);
    sb.push_back(e_same);
    bus_if.update_valid   = 1'b1;
    bus_if.update_is_jump = 1'b1;
    bus_if.update_pc      = 32'h300;
    bus_if.update_index   = e_same.idx;
    bus_if.update_taken   = 1'b1;
    bus_if.update_target  = 32'h500;
    #2;
    check_outputs("same_cycle_old");
    @(posedge clk);
    #1;
    bus_if.update_valid = 1'b0;
    model_update(1'b1, 32'h300, e_same.idx, 1'b1, 32'h500);
    lookup(32'h300, "same_cycle_new", idx_unused);

    // Reset wins over a simultaneous update
    update(1'b0, 32'hFFFF_FFFC, 5'd31, 1'b1, 32'h40, 1'b1);
    lookup(32'hFFFF_FFFC, "wrap_after_reset", idx_unused);
    lookup(32'h300, "btb_cleared", idx_unused);
    lookup(32'h100, "pht_hist_cleared", idx_unused);

    if (sb.size() != 0) begin
      n_total++;
      $error("FAIL scoreboard_drain: observed %0d left required 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
